// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - FSM states, geometry defaults and saturating MAC add for the systolic engine
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_e;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;
    localparam int ACC_W    = 64;

    // Cycles from the last accepted vector until the far corner PE has
    // consumed it: skew depth plus hops across the grid.
    function automatic int drain_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    localparam int DRAIN_LEN = drain_len(DEF_ROWS, DEF_COLS);

    // Adds a sign-extended product to a sign-extended accumulator. With
    // sat_en the sum is clamped to the signed bits_c range; otherwise the
    // caller truncates to bits_c, which gives two's-complement wrap.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [ACC_W-1:0] prod,
        input int                      bits_c,
        input logic                    sat_en
    );
        logic signed [ACC_W-1:0] sum;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        sum = acc + prod;
        hi  = (64'sd1 <<< (bits_c - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sat_en && (sum > hi)) begin
            return hi;
        end else if (sat_en && (sum < lo)) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one signed MAC cell with A/B pass-through, clear and preload
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int SAT     = 1
)(
    input  logic               clk,
    input  logic               rst_n,    // async, active low
    input  logic               en,       // advance: MAC and shift operands
    input  logic               clr,      // zero the accumulator
    input  logic               wr_en,    // preload accumulator from wr_data
    input  logic [BITS_C-1:0]  wr_data,
    input  logic [BITS_AB-1:0] a_in,     // from left neighbour / skew line
    input  logic [BITS_AB-1:0] b_in,     // from upper neighbour / skew line
    output logic [BITS_AB-1:0] a_out,    // to right neighbour
    output logic [BITS_AB-1:0] b_out,    // to lower neighbour
    output logic [BITS_C-1:0]  acc
);

    logic [BITS_AB-1:0]          a_q, a_d;
    logic [BITS_AB-1:0]          b_q, b_d;
    logic [BITS_C-1:0]           acc_q, acc_d;
    logic signed [2*BITS_AB-1:0] prod;

    always_comb begin
        prod  = signed'(a_in) * signed'(b_in);
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (wr_en) begin
            acc_d = wr_data;
        end else if (en) begin
            acc_d = BITS_C'(sat_add(ACC_W'(signed'(acc_q)), ACC_W'(prod), BITS_C, SAT != 0));
        end
        if (en) begin
            a_d = a_in;
            b_d = b_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - self-sequencing signed systolic matrix multiply C (+)= A*B
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int KBITS   = 8,
    parameter int SAT     = 1
)(
    input  logic                           clk,
    input  logic                           rst_n,     // async, active low
    input  logic                           start,     // begin a run (IDLE only)
    input  logic                           acc_mode,  // 0 clear C first, 1 accumulate
    input  logic [KBITS-1:0]               k_len,     // vector pairs in the run
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ROWS-1:0][BITS_AB-1:0]   A,         // A column k, unskewed
    input  logic [COLS-1:0][BITS_AB-1:0]   B,         // B row k, unskewed
    input  logic                           WrEn,      // preload row Crow (IDLE only)
    input  logic [$clog2(ROWS)-1:0]        Crow,
    input  logic [COLS-1:0][BITS_C-1:0]    Cin,
    output logic [COLS-1:0][BITS_C-1:0]    Cout,      // row Crow, one cycle later
    output logic                           busy,
    output logic                           done
);

    localparam int RW   = $clog2(ROWS);
    localparam int DLEN = drain_len(ROWS, COLS);
    localparam int DW   = $clog2(DLEN + 1);

    state_e              state_q, state_d;
    logic [KBITS-1:0]    klen_q, klen_d;
    logic [KBITS-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                done_q, done_d;
    logic                clr;
    logic                wr_ok;
    logic                hs;
    logic                adv;

    logic [BITS_AB-1:0]  a_inj [ROWS];
    logic [BITS_AB-1:0]  b_inj [COLS];
    logic [BITS_AB-1:0]  a_sk_q [ROWS][ROWS-1];
    logic [BITS_AB-1:0]  a_sk_d [ROWS][ROWS-1];
    logic [BITS_AB-1:0]  b_sk_q [COLS][COLS-1];
    logic [BITS_AB-1:0]  b_sk_d [COLS][COLS-1];
    logic [BITS_AB-1:0]  a_edge [ROWS];
    logic [BITS_AB-1:0]  b_edge [COLS];
    logic [BITS_AB-1:0]  a_in_w  [ROWS][COLS];
    logic [BITS_AB-1:0]  a_out_w [ROWS][COLS];
    logic [BITS_AB-1:0]  b_in_w  [ROWS][COLS];
    logic [BITS_AB-1:0]  b_out_w [ROWS][COLS];
    logic [BITS_C-1:0]   acc_w   [ROWS][COLS];
    logic [COLS-1:0][BITS_C-1:0] cout_q, cout_d;

    assign hs  = in_valid & in_ready_q;
    assign adv = busy_q;

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        clr     = 1'b0;
        wr_ok   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = ~acc_mode;
                    klen_d  = k_len;
                    cnt_d   = '0;
                    state_d = (k_len == '0) ? DONE : LOAD;
                end else begin
                    wr_ok = WrEn;   // start wins over a same-cycle preload
                end
            end
            LOAD: begin
                if (hs) begin
                    cnt_d = cnt_q + KBITS'(1);
                    if (cnt_d == klen_q) begin
                        state_d = DRAIN;
                        drain_d = DW'(DLEN);
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q - DW'(1);
                if (drain_q == DW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d == LOAD) || (state_d == DRAIN);
        in_ready_d = (state_d == LOAD);
        done_d     = (state_d == DONE);
    end

    // Idle LOAD cycles and all of DRAIN feed zeros, so bubbles add nothing.
    always_comb begin
        for (int r = 0; r < ROWS; r++) a_inj[r] = hs ? A[r] : '0;
        for (int c = 0; c < COLS; c++) b_inj[c] = hs ? B[c] : '0;
        a_sk_d = a_sk_q;
        b_sk_d = b_sk_q;
        if (adv) begin
            for (int r = 0; r < ROWS; r++) begin
                a_sk_d[r][0] = a_inj[r];
                for (int s = 1; s < ROWS - 1; s++) a_sk_d[r][s] = a_sk_q[r][s-1];
            end
            for (int c = 0; c < COLS; c++) begin
                b_sk_d[c][0] = b_inj[c];
                for (int s = 1; s < COLS - 1; s++) b_sk_d[c][s] = b_sk_q[c][s-1];
            end
        end
        cout_d = '0;
        if (int'(Crow) < ROWS) begin
            for (int c = 0; c < COLS; c++) cout_d[c] = acc_w[Crow][c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            klen_q     <= '0;
            cnt_q      <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            a_sk_q     <= '{default: '0};
            b_sk_q     <= '{default: '0};
            cout_q     <= '0;
        end else begin
            state_q    <= state_d;
            klen_q     <= klen_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            a_sk_q     <= a_sk_d;
            b_sk_q     <= b_sk_d;
            cout_q     <= cout_d;
        end
    end

    // Row r of A sees r skew stages; column c of B sees c stages.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_edge
        if (r == 0) begin : g_direct
            assign a_edge[r] = a_inj[r];
        end else begin : g_skew
            assign a_edge[r] = a_sk_q[r][r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_edge
        if (c == 0) begin : g_direct
            assign b_edge[c] = b_inj[c];
        end else begin : g_skew
            assign b_edge[c] = b_sk_q[c][c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c == 0) begin : g_a_left
                assign a_in_w[r][c] = a_edge[r];
            end else begin : g_a_inner
                assign a_in_w[r][c] = a_out_w[r][c-1];
            end
            if (r == 0) begin : g_b_top
                assign b_in_w[r][c] = b_edge[c];
            end else begin : g_b_inner
                assign b_in_w[r][c] = b_out_w[r-1][c];
            end

            systolic_pe #(
                .BITS_AB (BITS_AB),
                .BITS_C  (BITS_C),
                .SAT     (SAT)
            ) u_pe (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (adv),
                .clr     (clr),
                .wr_en   (wr_ok && (Crow == RW'(r))),
                .wr_data (Cin[c]),
                .a_in    (a_in_w[r][c]),
                .b_in    (b_in_w[r][c]),
                .a_out   (a_out_w[r][c]),
                .b_out   (b_out_w[r][c]),
                .acc     (acc_w[r][c])
            );
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign Cout     = cout_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - directed self-checking bench for systolic_mm_engine
module tb_systolic_mm_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int BAB  = 8;
    localparam int BC   = 16;
    localparam int KB   = 8;

    logic                      clk      = 1'b0;
    logic                      rst_n    = 1'b0;
    logic                      start    = 1'b0;
    logic                      acc_mode = 1'b0;
    logic [KB-1:0]             k_len    = '0;
    logic                      in_valid = 1'b0;
    logic [ROWS-1:0][BAB-1:0]  a_vec    = '0;
    logic [COLS-1:0][BAB-1:0]  b_vec    = '0;
    logic                      wr_en    = 1'b0;
    logic [2:0]                crow     = '0;
    logic [COLS-1:0][BC-1:0]   cin      = '0;
    logic [COLS-1:0][BC-1:0]   cout, cout_w;
    logic                      in_ready, in_ready_w;
    logic                      busy, busy_w;
    logic                      done, done_w;

    int cyc          = 0;
    int tests_run    = 0;
    int tests_failed = 0;

    systolic_mm_engine #(
        .ROWS(ROWS), .COLS(COLS), .BITS_AB(BAB), .BITS_C(BC), .KBITS(KB), .SAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .A(a_vec), .B(b_vec),
        .WrEn(wr_en), .Crow(crow), .Cin(cin), .Cout(cout), .busy(busy), .done(done)
    );

    systolic_mm_engine #(
        .ROWS(ROWS), .COLS(COLS), .BITS_AB(BAB), .BITS_C(BC), .KBITS(KB), .SAT(0)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready_w), .A(a_vec), .B(b_vec),
        .WrEn(wr_en), .Crow(crow), .Cin(cin), .Cout(cout_w), .busy(busy_w), .done(done_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_row(input int r, input int scen);
        logic [COLS-1:0][BC-1:0] row;
        int v;
        for (int c = 0; c < COLS; c++) begin
            case (scen)
                0:       v = 8 * r + c;
                1:       v = 8 * r + c + ((r == 3) ? 5 : 0);
                2:       v = 2 * (8 * r + c) + ((r == 3) ? 5 : 0);
                3:       v = 32767;
                4:       v = -32768;
                5:       v = -2040;
                6:       v = 1024;
                default: v = 0;
            endcase
            row[c] = 16'(v);
        end
        return row;
    endfunction

    task automatic set_vec(input int dset, input int k);
        for (int r = 0; r < ROWS; r++)
            a_vec[r] = (dset == 0) ? ((r == k) ? 8'd1 : 8'd0) : (dset == 1) ? 8'd127 : 8'h80;
        for (int c = 0; c < COLS; c++)
            b_vec[c] = (dset == 0) ? 8'(8 * k + c) : 8'd127;
    endtask

    task automatic check_rows(input string tag, input int scen, input int scen_w);
        for (int r = 0; r < ROWS; r++) begin
            crow = 3'(r);
            @(negedge clk);
            check_eq($sformatf("%s row%0d", tag, r), cout, exp_row(r, scen));
            if (scen_w >= 0)
                check_eq($sformatf("%s wrap row%0d", tag, r), cout_w, exp_row(r, scen_w));
        end
    endtask

    // poke: preload at start, start + k_len change in LOAD, preload in DRAIN.
    // abort > 0: pulse reset that many cycles into the drain wait.
    task automatic run_mm(input string tag, input logic accm, input int klen, input int bubbles,
                          input int dset, input bit poke, input int abort,
                          output int lat_start, output int lat_last);
        int k, it, t_start, t_last, rdy_bad, guard;
        bit v;
        @(negedge clk);
        start    = 1'b1;
        acc_mode = accm;
        k_len    = 8'(klen);
        if (poke) begin
            wr_en = 1'b1;
            crow  = 3'd3;
            cin   = {COLS{16'h7777}};
        end
        @(negedge clk);
        start   = 1'b0;
        wr_en   = 1'b0;
        t_start = cyc;
        t_last  = cyc;
        if (poke) k_len = 8'd3;
        k = 0; it = 0; rdy_bad = 0;
        while (k < klen && it < 64) begin
            v        = (bubbles == 0) || (it % 2 == 0);
            in_valid = v;
            set_vec(dset, k);
            start    = poke && (it == 2);
            if (poke && it == 2) acc_mode = 1'b0;
            if (in_ready !== 1'b1) rdy_bad++;
            @(negedge clk);
            if (v) begin
                k++;
                t_last = cyc;
            end
            it++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
        check_eq({tag, " in_ready in LOAD"}, rdy_bad, 0);
        if (poke && klen > 0) begin
            wr_en = 1'b1;
            crow  = 3'd3;
            cin   = {COLS{16'h7777}};
        end
        guard = 0;
        while (done !== 1'b1 && guard < 64) begin
            @(negedge clk);
            wr_en = 1'b0;
            guard++;
            if (abort > 0 && guard == abort) begin
                rst_n = 1'b0;
                #1;
                check_eq({tag, " busy in reset"}, busy, 0);
                check_eq({tag, " in_ready in reset"}, in_ready, 0);
                #2;
                rst_n = 1'b1;
            end
        end
        wr_en     = 1'b0;
        lat_start = (done === 1'b1) ? cyc - t_start : -1;
        lat_last  = (done === 1'b1) ? cyc - t_last : -1;
    endtask

    initial begin
        int ls, ll;
        repeat (3) @(negedge clk);
        check_eq("reset busy", busy, 0);
        check_eq("reset in_ready", in_ready, 0);
        check_eq("reset done", done, 0);
        check_eq("reset cout", cout, 0);
        rst_n = 1'b1;
        check_rows("reset", 9, 9);

        run_mm("t1", 1'b0, 8, 0, 0, 1'b0, 0, ls, ll);
        check_eq("t1 latency from start", ls, 23);
        check_eq("t1 latency from last", ll, 15);
        check_rows("t1", 0, 0);

        run_mm("t2", 1'b0, 8, 1, 0, 1'b0, 0, ls, ll);
        check_eq("t2 latency from start", ls, 30);
        check_eq("t2 latency from last", ll, 15);
        check_rows("t2", 0, -1);

        run_mm("k0", 1'b0, 0, 0, 0, 1'b0, 0, ls, ll);
        check_eq("k0 latency", ls, 0);
        check_eq("k0 busy", busy, 0);
        check_rows("k0", 9, 9);

        run_mm("poke", 1'b1, 8, 0, 0, 1'b1, 0, ls, ll);
        check_eq("poke latency from start", ls, 23);
        check_eq("poke latency from last", ll, 15);
        check_rows("poke", 0, -1);

        run_mm("k0b", 1'b0, 0, 0, 0, 1'b0, 0, ls, ll);
        check_eq("k0b latency", ls, 0);
        check_rows("k0b", 9, -1);

        @(negedge clk);
        wr_en = 1'b1;
        crow  = 3'd3;
        cin   = {COLS{16'd5}};
        @(negedge clk);
        wr_en = 1'b0;
        run_mm("t3a", 1'b1, 8, 0, 0, 1'b0, 0, ls, ll);
        check_eq("t3a latency", ls, 23);
        check_rows("t3a", 1, -1);
        run_mm("t3b", 1'b1, 8, 0, 0, 1'b0, 0, ls, ll);
        check_rows("t3b", 2, -1);

        run_mm("satp", 1'b0, 8, 0, 1, 1'b0, 0, ls, ll);
        check_rows("satp", 3, 5);
        run_mm("satn", 1'b0, 8, 0, 2, 1'b0, 0, ls, ll);
        check_rows("satn", 4, 6);

        run_mm("rst", 1'b0, 8, 0, 0, 1'b0, 5, ls, ll);
        check_eq("rst no done", ls, -1);
        check_eq("rst busy after", busy, 0);
        check_rows("rst", 9, 9);

        run_mm("t6", 1'b0, 8, 0, 0, 1'b0, 0, ls, ll);
        check_eq("t6 latency from start", ls, 23);
        check_rows("t6", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
